// File: rtl/mod_exp_pkg.sv
// -----------------------------------------------------------------------------
// mod_exp_pkg
// Shared definitions for the modular-exponentiation engine.
//   - default operand / exponent widths
//   - FSM state encodings for mod_exp_engine
//   - ct_latency(): accept-to-done edge count of the constant-time build
// No ports (package).
// -----------------------------------------------------------------------------
package mod_exp_pkg;

  localparam int DEFAULT_WIDTH = 6;
  localparam int DEFAULT_EXP_W = 6;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_SCAN = 3'd2;
  localparam logic [2:0] S_MUL  = 3'd3;
  localparam logic [2:0] S_SQR  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  // Reduction costs width+1, then every exponent bit costs
  // SCAN (1) + MUL (width+1) + SQR (width+1).
  function automatic int ct_latency(input int width, input int exp_w);
    return (width + 1) * (2 * exp_w + 1) + exp_w;
  endfunction

endpackage

// File: rtl/mod_exp_engine_if.sv
// -----------------------------------------------------------------------------
// mod_exp_engine_if
// Request/response bundle between the key/data registers and the engine.
//   start    : request, honoured only while ready is high
//   base     : message / ciphertext (may be >= modulus)
//   exponent : key (e or d)
//   modulus  : N
//   ready    : engine idle
//   done     : one-cycle pulse, result/error valid
//   error    : modulus < 2 for the current operation
//   result   : base^exponent mod modulus
// Modports: master (requester side), slave (engine side).
// -----------------------------------------------------------------------------
interface mod_exp_engine_if #(
  parameter int WIDTH = 6,
  parameter int EXP_W = 6
) ();

  logic             start;
  logic [WIDTH-1:0] base;
  logic [EXP_W-1:0] exponent;
  logic [WIDTH-1:0] modulus;
  logic             ready;
  logic             done;
  logic             error;
  logic [WIDTH-1:0] result;

  modport master (
    output start, base, exponent, modulus,
    input  ready, done, error, result
  );

  modport slave (
    input  start, base, exponent, modulus,
    output ready, done, error, result
  );

endinterface

// File: rtl/mod_mult.sv
// -----------------------------------------------------------------------------
// mod_mult
// Interleaved (Blakley) modular multiplier, MSB-first over a:
//   r = 2r + a_i*b ; subtract n up to twice so r < n.
// Operands need b < n; a may be any value.  One invocation is exactly
// WIDTH+1 cycles: the go cycle latches operands, then WIDTH iterations.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   go         : launch pulse (operands sampled with it)
//   a, b, n    : multiplicand, multiplier, modulus
//   busy       : iterations in progress
//   done       : high during the final iteration; p is valid in that cycle
//   p          : product a*b mod n (combinational next remainder)
// -----------------------------------------------------------------------------
module mod_mult #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] p
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] a_q, b_q, n_q, r_q;
  logic [CNT_W-1:0] cnt;
  // 2r + b < 3n < 2^(WIDTH+2), so two guard bits suffice.
  logic [WIDTH+1:0] r_sh, r_1, r_2;

  // NOTE: every always_comb output gets a value on every path (here by
  // straight-line assignment); a missing branch would infer a latch.
  always_comb begin
    r_sh = {1'b0, r_q, 1'b0} + (a_q[WIDTH-1] ? {2'b00, b_q} : '0);
    r_1  = (r_sh >= {2'b00, n_q}) ? r_sh - {2'b00, n_q} : r_sh;
    r_2  = (r_1  >= {2'b00, n_q}) ? r_1  - {2'b00, n_q} : r_1;
  end

  assign p    = r_2[WIDTH-1:0];
  assign busy = (cnt != '0);
  assign done = (cnt == CNT_W'(1));

  // NOTE: reset is synchronous (sampled only on the clock edge) and all
  // state registers use non-blocking assignment so every flop sees the
  // pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      n_q <= '0;
      r_q <= '0;
      cnt <= '0;
    end else if (go) begin
      a_q <= a;
      b_q <= b;
      n_q <= n;
      r_q <= '0;
      cnt <= CNT_W'(WIDTH);
    end else if (busy) begin
      r_q <= p;
      a_q <= a_q << 1;
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/mod_exp_engine.sv
// -----------------------------------------------------------------------------
// mod_exp_engine
// Sequential right-to-left square-and-multiply: result = base^exponent mod N.
// The FSM only sequences one mod_mult instance and the acc / b / exponent
// registers.  The base reduction (b = base*1 mod N) is launched on the accept
// edge itself, so LOAD spans the WIDTH iteration cycles.
// Ports:
//   clk  : clock, all logic on the rising edge
//   rst  : synchronous active-high reset, aborts any operation
//   bus  : mod_exp_engine_if.slave (start/operands in, ready/done/error/result)
// Build option:
//   MOD_EXP_CONST_TIME_EN - process every exponent bit and always run the
//   multiply (product discarded for 0 bits); fixed latency ct_latency().
// -----------------------------------------------------------------------------
module mod_exp_engine
  import mod_exp_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int EXP_W = DEFAULT_EXP_W
) (
  input logic             clk,
  input logic             rst,
  mod_exp_engine_if.slave bus
);

`ifdef MOD_EXP_CONST_TIME_EN
  localparam bit CONST_TIME = 1'b1;
`else
  localparam bit CONST_TIME = 1'b0;
`endif

  localparam int CNT_W = $clog2(EXP_W + 1);

  logic [2:0]       state;
  logic [WIDTH-1:0] acc, b_q, n_q, result_q;
  logic [EXP_W-1:0] exp_sh;
  logic [CNT_W-1:0] cnt;
  logic             error_q, go_q;

  logic             launch, mult_go, mult_busy, mult_done;
  logic [WIDTH-1:0] mult_a, mult_b, mult_n, mult_p;

  // Accept with modulus >= 2 starts the reduction in the same cycle.
  assign launch  = (state == S_IDLE) && bus.start && (bus.modulus[WIDTH-1:1] != '0);
  assign mult_go = launch || go_q;

  // Operand select: IDLE reduces the raw base, MUL is acc*b, SQR is b*b.
  always_comb begin
    mult_a = b_q;
    mult_b = b_q;
    mult_n = n_q;
    if (state == S_IDLE) begin
      mult_a = bus.base;
      mult_b = WIDTH'(1);
      mult_n = bus.modulus;
    end else if (state == S_MUL) begin
      mult_a = acc;
    end
  end

  mod_mult #(.WIDTH(WIDTH)) u_mult (
    .clk  (clk),
    .rst  (rst),
    .go   (mult_go),
    .a    (mult_a),
    .b    (mult_b),
    .n    (mult_n),
    .busy (mult_busy),
    .done (mult_done),
    .p    (mult_p)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      acc      <= '0;
      b_q      <= '0;
      n_q      <= '0;
      exp_sh   <= '0;
      cnt      <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
      go_q     <= 1'b0;
    end else begin
      go_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            b_q    <= bus.base;
            n_q    <= bus.modulus;
            exp_sh <= bus.exponent;
            if (launch) begin
              error_q <= 1'b0;
              state   <= S_LOAD;
            end else begin
              error_q  <= 1'b1;
              result_q <= '0;
              state    <= S_DONE;
            end
          end
        end
        S_LOAD: begin
          if (mult_done) begin
            b_q   <= mult_p;
            acc   <= WIDTH'(1);
            cnt   <= CNT_W'(EXP_W);
            state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (cnt == '0 || (!CONST_TIME && exp_sh == '0)) begin
            result_q <= acc;
            state    <= S_DONE;
          end else begin
            go_q  <= 1'b1;
            state <= (CONST_TIME || exp_sh[0]) ? S_MUL : S_SQR;
          end
        end
        S_MUL: begin
          if (mult_done) begin
            // In the constant-time build a 0 bit still multiplies; keep acc.
            if (exp_sh[0]) acc <= mult_p;
            go_q  <= 1'b1;
            state <= S_SQR;
          end
        end
        S_SQR: begin
          if (mult_done) begin
            b_q    <= mult_p;
            exp_sh <= exp_sh >> 1;
            cnt    <= cnt - 1'b1;
            // Constant-time: the last square ends the run directly so the
            // latency is exactly ct_latency() with no trailing SCAN.
            if (CONST_TIME && cnt == CNT_W'(1)) begin
              result_q <= acc;
              state    <= S_DONE;
            end else begin
              state <= S_SCAN;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ready  = (state == S_IDLE);
  assign bus.done   = (state == S_DONE);
  assign bus.error  = error_q;
  assign bus.result = result_q;

  // The multiplier is only ever busy inside LOAD, MUL or SQR.
  a_mult_idle : assert property (@(posedge clk) disable iff (rst)
    (state == S_IDLE || state == S_SCAN || state == S_DONE) |-> !mult_busy);

endmodule

// File: tb/tb_mod_exp_engine.sv
// -----------------------------------------------------------------------------
// tb_mod_exp_engine
// Self-checking bench for mod_exp_engine (WIDTH=6, EXP_W=6).  Expected
// results come from a plain pow-mod model; expected latency from the
// accept-to-done edge formulas.  Latency L means done is seen high in the
// cycle that ends at edge k+L, where k is the accept edge.
// -----------------------------------------------------------------------------
module tb_mod_exp_engine;
  import mod_exp_pkg::*;

  localparam int W         = DEFAULT_WIDTH;
  localparam int E         = DEFAULT_EXP_W;
  localparam int LAT_BOUND = 300;
  localparam int N_RANDOM  = 400;

`ifdef MOD_EXP_CONST_TIME_EN
  localparam bit CT = 1'b1;
`else
  localparam bit CT = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] result;
    logic         error;
    int           lat;
    int           n_done;
    int           n_ready;
    logic         ready_after;
    logic [W-1:0] result_after;
    logic         error_after;
  } op_t;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  mod_exp_engine_if #(.WIDTH(W), .EXP_W(E)) bus ();

  mod_exp_engine #(.WIDTH(W), .EXP_W(E)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int ref_pow(input int b, input int e, input int m);
    longint r;
    if (m < 2) return 0;
    r = 1;
    for (int i = 0; i < e; i++) r = (r * b) % m;
    return int'(r);
  endfunction

  function automatic int ref_lat(input int e, input int m);
    int lat;
    if (m < 2) return 1;
    if (CT) return ct_latency(W, E);
    lat = (W + 1) + 1;
    for (int i = 0; i < E; i++)
      if ((e >> i) != 0) lat += 1 + (W + 1) * (1 + ((e >> i) & 1));
    return lat;
  endfunction

  // Drives one request starting at a negedge with ready high, watches the
  // run, and returns at the negedge one cycle after done.  poke_at > 0
  // raises a stray start (random operands) in that cycle of the run.
  task automatic run_op(input int b, input int e, input int m, input int poke_at,
                        output op_t o);
    bus.start    = 1'b1;
    bus.base     = W'(b);
    bus.exponent = E'(e);
    bus.modulus  = W'(m);
    @(negedge clk);
    bus.start    = 1'b0;
    bus.base     = W'($urandom);
    bus.exponent = E'($urandom);
    bus.modulus  = W'($urandom);
    o.lat = -1; o.n_done = 0; o.n_ready = 0; o.result = '0; o.error = 1'b0;
    for (int i = 1; i <= LAT_BOUND && o.lat < 0; i++) begin
      if (bus.done === 1'b1) begin
        o.lat = i; o.result = bus.result; o.error = bus.error; o.n_done++;
      end else begin
        if (bus.ready !== 1'b0) o.n_ready++;
        bus.start = (i == poke_at);
        if (i == poke_at) begin
          bus.base = W'($urandom); bus.exponent = E'($urandom); bus.modulus = W'($urandom_range(2, 63));
        end
        @(negedge clk);
      end
    end
    bus.start = 1'b0;
    @(negedge clk);
    if (bus.done === 1'b1) o.n_done++;
    o.ready_after  = bus.ready;
    o.result_after = bus.result;
    o.error_after  = bus.error;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b0; bus.base = '0; bus.exponent = '0; bus.modulus = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({bus.ready, bus.done, bus.error, bus.result} !== {1'b1, 1'b0, 1'b0, W'(0)}) begin
      fails++;
      $display("FAIL reset_state: ready/done/error/result got %b/%b/%b/%0d want 1/0/0/0",
               bus.ready, bus.done, bus.error, bus.result);
    end
  endtask

  task automatic test_encrypt();
    op_t o;
    run_op(4, 7, 33, 0, o);
    tests++;
    if (o.result !== W'(16) || o.error !== 1'b0) begin
      fails++; $display("FAIL encrypt_result: got %0d err %b want 16 err 0", o.result, o.error);
    end
    tests++;
    if (o.lat !== (CT ? 97 : 53)) begin
      fails++; $display("FAIL encrypt_latency: got %0d want %0d", o.lat, CT ? 97 : 53);
    end
    tests++;
    if (o.n_done !== 1 || o.n_ready !== 0 || o.ready_after !== 1'b1) begin
      fails++; $display("FAIL encrypt_handshake: done pulses %0d ready-high cycles %0d ready after %b want 1/0/1",
                        o.n_done, o.n_ready, o.ready_after);
    end
    tests++;
    if (o.result_after !== W'(16)) begin
      fails++; $display("FAIL encrypt_hold: result after done %0d want 16", o.result_after);
    end
  endtask

  task automatic test_back_to_back();
    op_t o;
    // Called right after test_encrypt: the start goes in on the first
    // ready cycle.
    run_op(16, 3, 33, 0, o);
    tests++;
    if (o.result !== W'(4) || o.lat !== ref_lat(3, 33)) begin
      fails++; $display("FAIL decrypt_b2b: got %0d lat %0d want 4 lat %0d", o.result, o.lat, ref_lat(3, 33));
    end
  endtask

  task automatic test_operands();
    op_t o;
    int  vec [4][3] = '{'{40, 2, 33}, '{9, 0, 33}, '{0, 5, 33}, '{62, 63, 63}};
    int  want[4]    = '{16, 1, 0, 62};
    for (int i = 0; i < 4; i++) begin
      run_op(vec[i][0], vec[i][1], vec[i][2], 0, o);
      tests++;
      if (o.result !== W'(want[i]) || o.error !== 1'b0 || o.lat !== ref_lat(vec[i][1], vec[i][2])) begin
        fails++;
        $display("FAIL operands_%0d: %0d^%0d mod %0d got %0d err %b lat %0d want %0d err 0 lat %0d",
                 i, vec[i][0], vec[i][1], vec[i][2], o.result, o.error, o.lat, want[i],
                 ref_lat(vec[i][1], vec[i][2]));
      end
    end
  endtask

  task automatic test_error();
    op_t o;
    for (int m = 1; m >= 0; m--) begin
      run_op(5, 9, m, 0, o);
      tests++;
      if (o.error !== 1'b1 || o.result !== W'(0) || o.lat !== 1 || o.error_after !== 1'b1) begin
        fails++;
        $display("FAIL error_mod%0d: err %b result %0d lat %0d held err %b want 1 0 1 1",
                 m, o.error, o.result, o.lat, o.error_after);
      end
    end
    run_op(3, 4, 10, 0, o);
    tests++;
    if (o.error !== 1'b0 || o.result !== W'(1)) begin
      fails++; $display("FAIL error_clears: err %b result %0d want 0 1", o.error, o.result);
    end
  endtask

  task automatic test_start_ignored();
    op_t o;
    run_op(4, 7, 33, 10, o);
    tests++;
    if (o.result !== W'(16) || o.lat !== ref_lat(7, 33) || o.n_done !== 1) begin
      fails++; $display("FAIL start_in_mul: got %0d lat %0d pulses %0d want 16 lat %0d pulses 1",
                        o.result, o.lat, o.n_done, ref_lat(7, 33));
    end
  endtask

  task automatic test_reset_mid_sqr();
    op_t o;
    int  n_done = 0;
    bus.start = 1'b1; bus.base = W'(16); bus.exponent = E'(3); bus.modulus = W'(33);
    @(negedge clk);
    bus.start = 1'b0;
    // Cycles 15..21 after accept are the first square.
    for (int i = 1; i < 17; i++) begin
      if (bus.done === 1'b1) n_done++;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if ({bus.ready, bus.done, bus.error, bus.result} !== {1'b1, 1'b0, 1'b0, W'(0)} || n_done !== 0) begin
      fails++;
      $display("FAIL reset_mid_sqr: ready/done/error/result %b/%b/%b/%0d early dones %0d want 1/0/0/0 and 0",
               bus.ready, bus.done, bus.error, bus.result, n_done);
    end
    run_op(4, 7, 33, 0, o);
    tests++;
    if (o.result !== W'(16) || o.lat !== ref_lat(7, 33)) begin
      fails++; $display("FAIL after_reset: got %0d lat %0d want 16 lat %0d", o.result, o.lat, ref_lat(7, 33));
    end
  endtask

  task automatic test_random();
    op_t o;
    int  b, e, m, bad;
    bad = 0;
    for (int i = 0; i < N_RANDOM; i++) begin
      b = $urandom_range(0, 63);
      e = $urandom_range(0, 63);
      m = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 1) : $urandom_range(2, 63);
      run_op(b, e, m, 0, o);
      tests++;
      if (o.result !== W'(ref_pow(b, e, m)) || o.error !== (m < 2) || o.lat !== ref_lat(e, m) ||
          o.n_done !== 1 || o.n_ready !== 0 || o.ready_after !== 1'b1) begin
        fails++;
        if (bad < 10)
          $display("FAIL random_%0d: %0d^%0d mod %0d got %0d err %b lat %0d pulses %0d ready-high %0d want %0d err %0d lat %0d pulses 1 ready-high 0",
                   i, b, e, m, o.result, o.error, o.lat, o.n_done, o.n_ready,
                   ref_pow(b, e, m), (m < 2), ref_lat(e, m));
        bad++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_back_to_back();
    test_operands();
    test_error();
    test_start_ignored();
    test_reset_mid_sqr();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
